// File: rtl/nand_reduce_seq_pkg.sv
// Shared definitions for the chunked tree-NAND sequencer: FSM encodings and
// parameter legality helpers.
package nand_reduce_seq_pkg;

   typedef enum logic [1:0] {
      NRS_IDLE = 2'd0,
      NRS_RUN  = 2'd1,
      NRS_DONE = 2'd2
   } nrs_state_e;

   function automatic bit is_pow2(input int unsigned v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

   // Counter width; a single chunk still needs a one-bit counter.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 32'd1) ? 32'd1 : $clog2(v);
   endfunction

endpackage

// File: rtl/nand_reduce_seq_if.sv
// Operand/result handshake bundle between producer/consumer and the sequencer.
interface nand_reduce_seq_if #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned CHUNKS = 4
);
   logic              i_valid;
   logic [WIDTH-1:0]  i_data;
   logic              o_ready;
   logic              o_valid;
   logic              o_nand;
   logic [CHUNKS-1:0] o_chunks;
   logic              i_ready;

   modport slave (
      input  i_valid, i_data, i_ready,
      output o_ready, o_valid, o_nand, o_chunks
   );

   modport master (
      output i_valid, i_data, i_ready,
      input  o_ready, o_valid, o_nand, o_chunks
   );
endinterface

// File: rtl/nand_reduce_seq_tree_nand.sv
// Balanced binary NAND tree: each level NANDs adjacent pairs; a one-bit tree
// is a pass-through.
module tree_nand #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] i_data,
   output logic         o_nand
);

   generate
      if (W == 32'd1) begin : g_pass
         assign o_nand = i_data[0];
      end else begin : g_tree
         localparam int unsigned LEVELS = $clog2(W);
         logic [W-1:0] lvl_s;

         // In-place level reduction; slot k of a level only reads slots 2k, 2k+1.
         always_comb begin
            lvl_s = i_data;
            for (int l = 0; l < int'(LEVELS); l++) begin
               for (int k = 0; k < int'(W / 32'd2); k++) begin
                  lvl_s[k] = ~(lvl_s[2*k] & lvl_s[2*k+1]);
               end
            end
            o_nand = lvl_s[0];
         end
      end
   endgenerate

endmodule

// File: rtl/nand_reduce_seq.sv
// Time-multiplexed tree-NAND: evaluates one SLICE-wide chunk per cycle, then
// combines the chunk results through a CHUNKS-wide tree.
module nand_reduce_seq
   import nand_reduce_seq_pkg::*;
#(
   parameter  int unsigned WIDTH  = 64,
   parameter  int unsigned SLICE  = 16,
   localparam int unsigned CHUNKS = WIDTH / SLICE,
   localparam int unsigned CW     = clog2_min1(CHUNKS)
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   nand_reduce_seq_if.slave  bus
);

   generate
      if (!(is_pow2(WIDTH) && (WIDTH >= 32'd2) && is_pow2(SLICE) && (SLICE <= WIDTH))) begin : g_bad_params
         $error("nand_reduce_seq: illegal WIDTH/SLICE combination");
      end
   endgenerate

   nrs_state_e        state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CHUNKS-1:0] chunks_q, chunks_d;
   logic              nand_q, nand_d;

   logic [SLICE-1:0]  slice_in_s;
   logic [CHUNKS-1:0] comb_in_s;
   logic              slice_s;
   logic              comb_s;
   logic              last_s;

   assign slice_in_s = data_q[int'(cnt_q) * int'(SLICE) +: SLICE];
   assign last_s     = (cnt_q == CW'(CHUNKS - 32'd1));

   tree_nand #(.W(SLICE))  u_slice (.i_data(slice_in_s), .o_nand(slice_s));
   tree_nand #(.W(CHUNKS)) u_comb  (.i_data(comb_in_s),  .o_nand(comb_s));

   // Chunk vector with the in-flight slice result merged at position cnt.
   always_comb begin
      comb_in_s = chunks_q;
      for (int k = 0; k < int'(CHUNKS); k++) begin
         if (cnt_q == CW'(k)) begin
            comb_in_s[k] = slice_s;
         end else begin
            comb_in_s[k] = chunks_q[k];
         end
      end
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      chunks_d = chunks_q;
      nand_d   = nand_q;
      case (state_q)
         NRS_IDLE: begin
            if (bus.i_valid) begin
               data_d   = bus.i_data;
               cnt_d    = {CW{1'b0}};
               chunks_d = {CHUNKS{1'b0}};
               state_d  = NRS_RUN;
            end else begin
               state_d  = NRS_IDLE;
            end
         end
         NRS_RUN: begin
            chunks_d = comb_in_s;
            if (last_s) begin
               nand_d  = comb_s;
               cnt_d   = {CW{1'b0}};
               state_d = NRS_DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = NRS_RUN;
            end
         end
         NRS_DONE: begin
            if (bus.i_ready) begin
               state_d = NRS_IDLE;
            end else begin
               state_d = NRS_DONE;
            end
         end
         default: begin
            state_d = NRS_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= NRS_IDLE;
         data_q   <= {WIDTH{1'b0}};
         cnt_q    <= {CW{1'b0}};
         chunks_q <= {CHUNKS{1'b0}};
         nand_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         chunks_q <= chunks_d;
         nand_q   <= nand_d;
      end
   end

   assign bus.o_ready  = (state_q == NRS_IDLE);
   assign bus.o_valid  = (state_q == NRS_DONE);
   assign bus.o_nand   = nand_q;
   assign bus.o_chunks = chunks_q;

endmodule
